// File: rtl/pipeline_trace_monitor.sv
// In-design pipeline monitor: saturating event counters plus a first-word-fall-through
// trace FIFO of register-writeback retirements, drained by valid/ready.
module pipeline_trace_monitor #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TRACE_DEPTH    = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              clear,
   input  logic                              stall_f,
   input  logic                              stall_d,
   input  logic                              flush_d,
   input  logic                              flush_e,
   input  logic                              pc_src_e,
   input  logic                              mem_write_m,
   input  logic                              mem_read_m,
   input  logic                              retire_valid_w,
   input  logic                              reg_write_w,
   input  logic [REG_ADDR_WIDTH-1:0]         rd_w,
   input  logic [DATA_WIDTH-1:0]             result_w,
   input  logic [DATA_WIDTH-1:0]             pc_w,
   input  logic [2:0]                        cnt_sel,
   output logic [CNT_WIDTH-1:0]              cnt_value,
   output logic                              trace_valid,
   input  logic                              trace_ready,
   output logic [DATA_WIDTH-1:0]             trace_pc,
   output logic [REG_ADDR_WIDTH-1:0]         trace_rd,
   output logic [DATA_WIDTH-1:0]             trace_data,
   output logic [$clog2(TRACE_DEPTH):0]      trace_count,
   output logic                              overflow
);

   localparam int unsigned PtrW   = $clog2(TRACE_DEPTH);
   localparam int unsigned OccW   = PtrW + 1;
   localparam int unsigned EntryW = 2 * DATA_WIDTH + REG_ADDR_WIDTH;

   logic [CNT_WIDTH-1:0] cnt_q [8];
   logic [CNT_WIDTH-1:0] cnt_d [8];
   logic [CNT_WIDTH-1:0] cnt_value_q, cnt_value_d;
   logic [EntryW-1:0]    mem_q [TRACE_DEPTH];
   logic [EntryW-1:0]    mem_d [TRACE_DEPTH];
   logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OccW-1:0]      count_q, count_d;
   logic                 overflow_q, overflow_d;

   logic [7:0]        event_hit;
   logic              push_req, pop, full, push_ok, drop;
   logic [EntryW-1:0] head;

   assign push_req = enable & retire_valid_w & reg_write_w & (rd_w != '0);
   assign pop      = trace_valid & trace_ready;
   assign full     = (count_q == OccW'(TRACE_DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_comb begin
      event_hit    = '0;
      event_hit[0] = 1'b1;
      event_hit[1] = retire_valid_w;
      event_hit[2] = stall_f | stall_d;
      event_hit[3] = flush_d | flush_e;
      event_hit[4] = pc_src_e;
      event_hit[5] = mem_read_m;
      event_hit[6] = mem_write_m;
      event_hit[7] = drop;
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear) begin
            cnt_d[i] = '0;
         end else if (enable && event_hit[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
      cnt_value_d = cnt_q[cnt_sel];
   end

   always_comb begin
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clear) begin
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_ok) begin
            mem_d[wptr_q] = {pc_w, rd_w, result_w};
            wptr_d        = wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   count_d = count_q + OccW'(1);
            2'b01:   count_d = count_q - OccW'(1);
            default: count_d = count_q;
         endcase
         if (drop) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
         cnt_value_q <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         cnt_value_q <= cnt_value_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage needs no reset; the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head        = mem_q[rptr_q];
   assign trace_valid = (count_q != '0);
   assign trace_pc    = trace_valid ? head[EntryW-1 -: DATA_WIDTH] : '0;
   assign trace_rd    = trace_valid ? head[DATA_WIDTH +: REG_ADDR_WIDTH] : '0;
   assign trace_data  = trace_valid ? head[DATA_WIDTH-1:0] : '0;
   assign trace_count = count_q;
   assign overflow    = overflow_q;
   assign cnt_value   = cnt_value_q;

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed bench for pipeline_trace_monitor: a 4-deep instance for counters and FIFO,
// plus a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_pipeline_trace_monitor;

   logic        clk = 1'b0;
   logic        rst, enable, clear;
   logic        stall_f, stall_d, flush_d, flush_e, pc_src_e;
   logic        mem_write_m, mem_read_m, retire_valid_w, reg_write_w;
   logic [4:0]  rd_w;
   logic [31:0] result_w, pc_w;
   logic [2:0]  cnt_sel;
   logic        trace_ready;

   logic [31:0] a_cnt_value, a_trace_pc, a_trace_data;
   logic        a_trace_valid, a_overflow;
   logic [4:0]  a_trace_rd;
   logic [2:0]  a_trace_count;

   logic [3:0]  b_cnt_value;
   logic [31:0] b_trace_pc, b_trace_data;
   logic        b_trace_valid, b_overflow;
   logic [4:0]  b_trace_rd;
   logic [4:0]  b_trace_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_trace_monitor #(.TRACE_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .pc_src_e(pc_src_e), .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
      .retire_valid_w(retire_valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
      .result_w(result_w), .pc_w(pc_w), .cnt_sel(cnt_sel), .cnt_value(a_cnt_value),
      .trace_valid(a_trace_valid), .trace_ready(trace_ready), .trace_pc(a_trace_pc),
      .trace_rd(a_trace_rd), .trace_data(a_trace_data), .trace_count(a_trace_count),
      .overflow(a_overflow)
   );

   pipeline_trace_monitor #(.CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .pc_src_e(pc_src_e), .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
      .retire_valid_w(retire_valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
      .result_w(result_w), .pc_w(pc_w), .cnt_sel(cnt_sel), .cnt_value(b_cnt_value),
      .trace_valid(b_trace_valid), .trace_ready(trace_ready), .trace_pc(b_trace_pc),
      .trace_rd(b_trace_rd), .trace_data(b_trace_data), .trace_count(b_trace_count),
      .overflow(b_overflow)
   );

   typedef struct {
      int en, stall, flush, br, ld, st, ret, rw, rd, res, pc, rdy, sel;
      int e_cnt, e_valid, e_count, e_rd, e_data, e_pc, e_ovf;
   } vec_t;

   vec_t vecs [14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_head(input string tag, input int valid, input int count, input int rd,
                             input int data, input int pc, input int ovf);
      check({tag, " valid"}, 32'(a_trace_valid), valid);
      check({tag, " count"}, 32'(a_trace_count), count);
      check({tag, " rd"}, 32'(a_trace_rd), rd);
      check({tag, " data"}, a_trace_data, data);
      check({tag, " pc"}, a_trace_pc, pc);
      check({tag, " overflow"}, 32'(a_overflow), ovf);
   endtask

   task automatic idle_inputs();
      enable = 1'b0; clear = 1'b0;
      stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0; pc_src_e = 1'b0;
      mem_write_m = 1'b0; mem_read_m = 1'b0; retire_valid_w = 1'b0; reg_write_w = 1'b0;
      rd_w = '0; result_w = '0; pc_w = '0; cnt_sel = '0; trace_ready = 1'b0;
   endtask

   task automatic push(input int rd, input int res, input int pc, input logic rdy);
      enable = 1'b1; retire_valid_w = 1'b1; reg_write_w = 1'b1;
      rd_w = rd[4:0]; result_w = res; pc_w = pc; trace_ready = rdy;
      step();
      retire_valid_w = 1'b0; reg_write_w = 1'b0; trace_ready = 1'b0;
   endtask

   // Counters are read with enable=0 so the readout itself does not move them.
   task automatic read_cnt(input int sel, input int exp, input string name);
      enable = 1'b0; cnt_sel = sel[2:0];
      step();
      check(name, a_cnt_value, exp);
   endtask

   initial begin
      // en,stall,flush,br,ld,st,ret,rw,rd,res,pc,rdy,sel | cnt,valid,count,rd,data,pc,ovf
      vecs[0]  = '{1,0,0,0,0,0,1,1,5,'h1234,'h10,0,0,  10,1,1,5,'h1234,'h10,0};
      vecs[1]  = '{1,0,0,0,0,0,1,1,0,'h55,'h14,0,1,    1,1,1,5,'h1234,'h10,0};
      vecs[2]  = '{1,1,0,0,0,0,0,0,0,0,0,0,1,          2,1,1,5,'h1234,'h10,0};
      vecs[3]  = '{1,1,1,0,0,0,0,0,0,0,0,0,2,          1,1,1,5,'h1234,'h10,0};
      vecs[4]  = '{1,1,0,1,0,0,0,0,0,0,0,0,3,          1,1,1,5,'h1234,'h10,0};
      vecs[5]  = '{1,0,0,1,1,0,0,0,0,0,0,0,4,          1,1,1,5,'h1234,'h10,0};
      vecs[6]  = '{0,0,0,0,0,1,0,0,0,0,0,0,5,          1,1,1,5,'h1234,'h10,0};
      vecs[7]  = '{1,0,0,0,0,1,0,0,0,0,0,0,6,          0,1,1,5,'h1234,'h10,0};
      vecs[8]  = '{1,0,0,0,0,0,0,0,0,0,0,0,2,          3,1,1,5,'h1234,'h10,0};
      vecs[9]  = '{1,0,0,0,0,0,0,0,0,0,0,0,3,          1,1,1,5,'h1234,'h10,0};
      vecs[10] = '{1,0,0,0,0,0,0,0,0,0,0,0,4,          2,1,1,5,'h1234,'h10,0};
      vecs[11] = '{1,0,0,0,0,0,0,0,0,0,0,0,6,          1,1,1,5,'h1234,'h10,0};
      vecs[12] = '{0,0,0,0,0,0,0,0,0,0,0,1,0,          21,0,0,0,0,0,0};
      vecs[13] = '{1,0,0,0,0,0,0,0,0,0,0,1,0,          21,0,0,0,0,0,0};

      idle_inputs();
      rst = 1'b0;
      step();
      step();
      check("reset cnt_value", a_cnt_value, 0);
      check_head("reset", 0, 0, 0, 0, 0, 0);

      // Ten idle enabled cycles.
      rst = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) step();
      read_cnt(0, 10, "idle cycles");
      for (int s = 1; s < 8; s++) read_cnt(s, 0, $sformatf("idle counter %0d", s));
      check("idle trace_valid", 32'(a_trace_valid), 0);

      for (int i = 0; i < 14; i++) begin
         enable = vecs[i].en[0];
         stall_f = vecs[i].stall[0]; stall_d = vecs[i].stall[0];
         flush_e = vecs[i].flush[0]; pc_src_e = vecs[i].br[0];
         mem_read_m = vecs[i].ld[0]; mem_write_m = vecs[i].st[0];
         retire_valid_w = vecs[i].ret[0]; reg_write_w = vecs[i].rw[0];
         rd_w = vecs[i].rd[4:0]; result_w = vecs[i].res; pc_w = vecs[i].pc;
         trace_ready = vecs[i].rdy[0]; cnt_sel = vecs[i].sel[2:0];
         step();
         check($sformatf("vec%0d cnt_value", i), a_cnt_value, vecs[i].e_cnt);
         check_head($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_count, vecs[i].e_rd,
                    vecs[i].e_data, vecs[i].e_pc, vecs[i].e_ovf);
      end
      idle_inputs();

      // Overflow: six pushes into a 4-deep FIFO with no consumer.
      for (int i = 0; i < 6; i++) push(i + 1, 'h100 + i, 'h200 + 4 * i, 1'b0);
      check_head("full", 1, 4, 1, 'h100, 'h200, 1);
      read_cnt(7, 2, "dropped after overflow");
      push(7, 'h106, 'h218, 1'b1);
      check_head("push+pop at full", 1, 4, 2, 'h101, 'h204, 1);
      read_cnt(7, 2, "dropped unchanged");
      begin
         int exp_idx [4] = '{1, 2, 3, 6};
         enable = 1'b0;
         trace_ready = 1'b1;
         for (int k = 0; k < 4; k++) begin
            check_head($sformatf("drain%0d", k), 1, 4 - k, exp_idx[k] + 1, 'h100 + exp_idx[k],
                       'h200 + 4 * exp_idx[k], 1);
            step();
         end
         trace_ready = 1'b0;
      end
      check_head("drained", 0, 0, 0, 0, 0, 1);

      // Clear with a simultaneous push.
      for (int i = 0; i < 3; i++) push(10 + i, 'h300 + i, 'h400 + 4 * i, 1'b0);
      check("pre-clear count", 32'(a_trace_count), 3);
      clear = 1'b1;
      enable = 1'b1; retire_valid_w = 1'b1; reg_write_w = 1'b1; stall_f = 1'b1;
      rd_w = 5'd13; result_w = 'h303; pc_w = 'h40c;
      step();
      idle_inputs();
      check_head("after clear", 0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 8; s++) read_cnt(s, 0, $sformatf("cleared counter %0d", s));

      // Reset while busy.
      stall_f = 1'b1;
      push(20, 'h500, 'h600, 1'b0);
      push(21, 'h501, 'h604, 1'b0);
      check("pre-reset count", 32'(a_trace_count), 2);
      enable = 1'b1; retire_valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd22;
      cnt_sel = 3'd0; rst = 1'b0;
      step();
      check("reset cnt_value busy", a_cnt_value, 0);
      check_head("reset busy", 0, 0, 0, 0, 0, 0);
      idle_inputs();
      rst = 1'b1;
      for (int s = 0; s < 3; s++) read_cnt(s, 0, $sformatf("post-reset counter %0d", s));

      // Saturation on the 4-bit instance.
      rst = 1'b0;
      step();
      rst = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 20; i++) step();
      enable = 1'b0;
      cnt_sel = 3'd0;
      step();
      check("4-bit cycles saturated", 32'(b_cnt_value), 15);
      check("32-bit cycles", a_cnt_value, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
